// File: rtl/fft_frame_sequencer.sv
// Single-FSM controller that walks one 8-point FFT frame through ROM -> SIPO -> FFT -> PISO,
// with start/busy/done handshake, abort, continuous mode and a completed-frame counter.
module fft_frame_sequencer #(
  parameter int N_POINTS = 8,
  parameter int ADDR_W   = 4,
  parameter int ROM_LAT  = 1,
  parameter int FFT_CYC  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cont,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              rom_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic              sipo_en,
  output logic              fft_en,
  output logic              piso_load,
  output logic              piso_en,
  output logic              out_valid,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [7:0]        frame_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, UNLOAD, DONE} state_t;

  localparam logic [7:0] LOAD_LAST   = 8'(N_POINTS + ROM_LAT - 1);
  localparam logic [7:0] COMP_LAST   = 8'(FFT_CYC - 1);
  localparam logic [7:0] UNLOAD_LAST = 8'(N_POINTS);
  localparam logic [7:0] NPTS        = 8'(N_POINTS);
  localparam logic [7:0] RLAT        = 8'(ROM_LAT);

  state_t            state;
  logic [7:0]        cnt;
  logic [7:0]        cnt_nxt;
  logic [ADDR_W-1:0] base;

  assign cnt_nxt = cnt + 8'd1;

  // Outputs are written together with the state they belong to, so every output is a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      base        <= '0;
      rom_en      <= 1'b0;
      mem_address <= '0;
      sipo_en     <= 1'b0;
      fft_en      <= 1'b0;
      piso_load   <= 1'b0;
      piso_en     <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      aborted     <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      rom_en    <= 1'b0;
      sipo_en   <= 1'b0;
      fft_en    <= 1'b0;
      piso_load <= 1'b0;
      piso_en   <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;

      if (abort && (state == LOAD || state == COMPUTE || state == UNLOAD)) begin
        state   <= IDLE;
        cnt     <= '0;
        busy    <= 1'b0;
        aborted <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state       <= LOAD;
              cnt         <= '0;
              base        <= base_addr;
              rom_en      <= 1'b1;
              mem_address <= base_addr;
              sipo_en     <= (ROM_LAT == 0);
              busy        <= 1'b1;
            end
          end

          LOAD: begin
            if (cnt == LOAD_LAST) begin
              state  <= COMPUTE;
              cnt    <= '0;
              fft_en <= 1'b1;
            end else begin
              cnt     <= cnt_nxt;
              rom_en  <= (cnt_nxt < NPTS);
              sipo_en <= (cnt_nxt >= RLAT) && (cnt_nxt <= LOAD_LAST);
              if (cnt_nxt < NPTS)
                mem_address <= base + ADDR_W'(cnt_nxt);
            end
          end

          COMPUTE: begin
            if (cnt == COMP_LAST) begin
              state     <= UNLOAD;
              cnt       <= '0;
              piso_load <= 1'b1;
              piso_en   <= 1'b1;
            end else begin
              cnt    <= cnt_nxt;
              fft_en <= 1'b1;
            end
          end

          UNLOAD: begin
            if (cnt == UNLOAD_LAST) begin
              state     <= DONE;
              cnt       <= '0;
              done      <= 1'b1;
              frame_cnt <= frame_cnt + 8'd1;
            end else begin
              cnt       <= cnt_nxt;
              piso_en   <= 1'b1;
              out_valid <= 1'b1;
            end
          end

          DONE: begin
            // A late abort still lets this frame count, but suppresses the continuous restart.
            if (cont && !abort) begin
              state       <= LOAD;
              cnt         <= '0;
              base        <= base_addr;
              rom_en      <= 1'b1;
              mem_address <= base_addr;
              sipo_en     <= (ROM_LAT == 0);
              busy        <= 1'b1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
              busy  <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Self-checking bench for fft_frame_sequencer: cycle table per scenario plus address/done scoreboards.
module tb_fft_frame_sequencer;

  localparam int NP = 8;
  localparam int RL = 1;
  localparam int FC = 2;
  localparam int AW = 4;
  localparam int K_LD_END   = NP + RL;
  localparam int K_CP_END   = K_LD_END + FC;
  localparam int K_UL_START = K_CP_END + 1;
  localparam int K_UL_END   = K_UL_START + NP;
  localparam int K_DN       = K_UL_END + 1;
  localparam int PERIOD     = K_DN;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          cont = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          rom_en, sipo_en, fft_en, piso_load, piso_en, out_valid, busy, done, aborted;
  logic [AW-1:0] mem_address;
  logic [7:0]    frame_cnt;
  logic [8:0]    ctrl;

  int            total = 0;
  int            bad = 0;
  logic [AW-1:0] addr_q[$];
  logic [7:0]    done_q[$];
  logic [7:0]    exp_cnt = '0;

  fft_frame_sequencer #(.N_POINTS(NP), .ADDR_W(AW), .ROM_LAT(RL), .FFT_CYC(FC)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .cont(cont), .base_addr(base_addr),
    .rom_en(rom_en), .mem_address(mem_address), .sipo_en(sipo_en), .fft_en(fft_en),
    .piso_load(piso_load), .piso_en(piso_en), .out_valid(out_valid), .busy(busy),
    .done(done), .aborted(aborted), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  assign ctrl = {rom_en, sipo_en, fft_en, piso_load, piso_en, out_valid, busy, done, aborted};

  // Expected control vector for cycle k of a frame whose start was sampled at cycle 0.
  function automatic logic [8:0] exp_ctrl(input int k);
    logic [8:0] v;
    v    = '0;
    v[8] = (k >= 1) && (k <= NP);
    v[7] = (k >= 1 + RL) && (k <= K_LD_END);
    v[6] = (k > K_LD_END) && (k <= K_CP_END);
    v[5] = (k == K_UL_START);
    v[4] = (k >= K_UL_START) && (k <= K_UL_END);
    v[3] = (k > K_UL_START) && (k <= K_UL_END);
    v[2] = (k >= 1) && (k <= K_DN);
    v[1] = (k == K_DN);
    v[0] = 1'b0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (rom_en) begin
        total++;
        if (addr_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL addr_sb unexpected rom_en addr=%0d", mem_address);
        end else begin
          logic [AW-1:0] ea;
          ea = addr_q.pop_front();
          if (mem_address !== ea) begin
            bad++;
            $display("[TB] FAIL addr_sb got=%0d want=%0d", mem_address, ea);
          end
        end
      end
      if (done) begin
        total++;
        if (done_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL done_sb unexpected done frame_cnt=%0d", frame_cnt);
        end else begin
          logic [7:0] ec;
          ec = done_q.pop_front();
          if (frame_cnt !== ec) begin
            bad++;
            $display("[TB] FAIL done_sb frame_cnt got=%0d want=%0d", frame_cnt, ec);
          end
        end
      end
    end
  end

  task automatic push_frame(input logic [AW-1:0] b, input bit expect_done);
    for (int i = 0; i < NP; i++) addr_q.push_back(b + AW'(i));
    if (expect_done) begin
      exp_cnt = exp_cnt + 8'd1;
      done_q.push_back(exp_cnt);
    end
  endtask

  // Returns at the negedge of cycle 1.
  task automatic pulse_start(input logic [AW-1:0] b, input bit expect_done);
    @(negedge clk);
    start     = 1'b1;
    base_addr = b;
    push_frame(b, expect_done);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    total++;
    if (ctrl !== 9'b0) begin bad++; $display("[TB] FAIL reset_ctrl got=%b want=0", ctrl); end
    total++;
    if (mem_address !== '0) begin bad++; $display("[TB] FAIL reset_addr got=%0d want=0", mem_address); end
    total++;
    if (frame_cnt !== 8'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d want=0", frame_cnt); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_single_frame();
    pulse_start(4'd0, 1'b1);
    for (int k = 1; k <= K_DN + 1; k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (ctrl !== exp_ctrl(k)) begin
        bad++; $display("[TB] FAIL single_ctrl k=%0d got=%b want=%b", k, ctrl, exp_ctrl(k));
      end
      total++;
      if (frame_cnt !== ((k >= K_DN) ? exp_cnt : exp_cnt - 8'd1)) begin
        bad++; $display("[TB] FAIL single_cnt k=%0d got=%0d", k, frame_cnt);
      end
    end
  endtask

  task automatic test_addr_wrap();
    logic [AW-1:0] ea;
    pulse_start(4'd12, 1'b1);
    for (int k = 1; k <= K_DN + 1; k++) begin
      if (k > 1) @(negedge clk);
      ea = 4'd12 + AW'((k <= NP) ? k - 1 : NP - 1);
      total++;
      if (ctrl !== exp_ctrl(k)) begin
        bad++; $display("[TB] FAIL wrap_ctrl k=%0d got=%b want=%b", k, ctrl, exp_ctrl(k));
      end
      total++;
      if (mem_address !== ea) begin
        bad++; $display("[TB] FAIL wrap_addr k=%0d got=%0d want=%0d", k, mem_address, ea);
      end
    end
  endtask

  task automatic test_continuous();
    int kk;
    int f;
    int seen;
    logic [AW-1:0] ea;
    seen = 0;
    cont = 1'b1;
    pulse_start(4'd2, 1'b1);
    base_addr = 4'd5;
    push_frame(4'd5, 1'b1);
    push_frame(4'd5, 1'b1);
    for (int k = 1; k <= 3 * PERIOD + 1; k++) begin
      if (k > 1) @(negedge clk);
      kk = (k == 3 * PERIOD + 1) ? K_DN + 1 : ((k - 1) % PERIOD) + 1;
      f  = (k - 1) / PERIOD;
      if (done) seen++;
      total++;
      if (ctrl !== exp_ctrl(kk)) begin
        bad++; $display("[TB] FAIL cont_ctrl k=%0d got=%b want=%b", k, ctrl, exp_ctrl(kk));
      end
      if (kk <= NP && f < 3) begin
        ea = ((f == 0) ? 4'd2 : 4'd5) + AW'(kk - 1);
        total++;
        if (mem_address !== ea) begin
          bad++; $display("[TB] FAIL cont_addr k=%0d got=%0d want=%0d", k, mem_address, ea);
        end
      end
      if (k == 50) cont = 1'b0;
    end
    total++;
    if (seen !== 3) begin bad++; $display("[TB] FAIL cont_done_count got=%0d want=3", seen); end
    total++;
    if (frame_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL cont_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_abort();
    logic [7:0] pre;
    pre = exp_cnt;
    pulse_start(4'd0, 1'b0);
    for (int k = 1; k <= K_LD_END + 1; k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (ctrl !== exp_ctrl(k)) begin
        bad++; $display("[TB] FAIL abort_pre k=%0d got=%b want=%b", k, ctrl, exp_ctrl(k));
      end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    total++;
    if (ctrl !== 9'b000000001) begin bad++; $display("[TB] FAIL abort_pulse got=%b want=000000001", ctrl); end
    total++;
    if (frame_cnt !== pre) begin bad++; $display("[TB] FAIL abort_cnt got=%0d want=%0d", frame_cnt, pre); end
    @(negedge clk);
    total++;
    if (ctrl !== 9'b0) begin bad++; $display("[TB] FAIL abort_idle got=%b want=0", ctrl); end
    abort = 1'b1;
    pulse_start(4'd9, 1'b1);
    abort = 1'b0;
    for (int k = 1; k <= K_DN + 1; k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (ctrl !== exp_ctrl(k)) begin
        bad++; $display("[TB] FAIL abort_restart k=%0d got=%b want=%b", k, ctrl, exp_ctrl(k));
      end
    end
    total++;
    if (frame_cnt !== exp_cnt) begin bad++; $display("[TB] FAIL abort_restart_cnt got=%0d want=%0d", frame_cnt, exp_cnt); end
  endtask

  task automatic test_async_reset();
    pulse_start(4'd3, 1'b0);
    for (int k = 2; k <= 15; k++) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    total++;
    if (ctrl !== 9'b0) begin bad++; $display("[TB] FAIL areset_ctrl got=%b want=0", ctrl); end
    total++;
    if (mem_address !== '0) begin bad++; $display("[TB] FAIL areset_addr got=%0d want=0", mem_address); end
    total++;
    if (frame_cnt !== 8'd0) begin bad++; $display("[TB] FAIL areset_cnt got=%0d want=0", frame_cnt); end
    exp_cnt = '0;
    done_q.delete();
    @(negedge clk);
    rst = 1'b1;
    pulse_start(4'd1, 1'b1);
    for (int k = 1; k <= K_DN + 1; k++) begin
      if (k > 1) @(negedge clk);
      total++;
      if (ctrl !== exp_ctrl(k)) begin
        bad++; $display("[TB] FAIL busy_start k=%0d got=%b want=%b", k, ctrl, exp_ctrl(k));
      end
      if (k == 5) start = 1'b1;
      if (k == 6) start = 1'b0;
    end
    total++;
    if (frame_cnt !== 8'd1) begin bad++; $display("[TB] FAIL busy_start_cnt got=%0d want=1", frame_cnt); end
  endtask

  task automatic test_cnt_wrap();
    int seen;
    int cyc;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_cnt = '0;
    addr_q.delete();
    done_q.delete();
    cont = 1'b1;
    pulse_start(4'd7, 1'b1);
    for (int f = 1; f < 256; f++) push_frame(4'd7, 1'b1);
    seen = 0;
    cyc  = 0;
    while (seen < 256 && cyc < 256 * PERIOD + 40) begin
      if (done) seen++;
      if (seen == 255 && !done) cont = 1'b0;
      if (seen < 256) begin
        @(negedge clk);
        cyc++;
      end
    end
    cont = 1'b0;
    total++;
    if (seen !== 256) begin bad++; $display("[TB] FAIL wrap_done_count got=%0d want=256", seen); end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL wrap_busy got=%b want=0", busy); end
    total++;
    if (frame_cnt !== 8'd0) begin bad++; $display("[TB] FAIL wrap_cnt got=%0d want=0", frame_cnt); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single_frame();
    test_addr_wrap();
    test_continuous();
    test_abort();
    test_async_reset();
    test_cnt_wrap();
    repeat (2) @(negedge clk);
    total++;
    if (addr_q.size() != 0) begin bad++; $display("[TB] FAIL addr_sb_left got=%0d want=0", addr_q.size()); end
    total++;
    if (done_q.size() != 0) begin bad++; $display("[TB] FAIL done_sb_left got=%0d want=0", done_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
